dst4x4_ctrl: RTL and testbench

Streaming sequencer around the combinational 4x4 DST core (dst4x4_top).
- Collects four residual rows over a valid/ready input stream into a block buffer.
- Presents the buffered block to the core for one evaluation cycle and registers the coefficient block.
- Streams the four coefficient rows out under valid/ready backpressure.
- Sits between the residual generator and the quantiser in the transform stage.

---
 rtl/dst_pkg.sv | 52 +++++
 rtl/dst4x4_top.sv | 63 ++++++
 rtl/dst4x4_ctrl.sv | 122 ++++++++++++
 tb/tb_dst4x4_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dst_pkg.sv
// Shared types for the 4x4 DST transform stage: FSM states, row arrays
// and helpers that convert between flat row buses and per-sample arrays.
package dst_pkg;

    localparam int N    = 4;
    localparam int RES_W = 12;
    localparam int CF_W  = 16;

    typedef enum logic [1:0] {
        FILL,
        XFORM,
        DRAIN
    } state_t;

    typedef logic signed [RES_W-1:0] res_row_t [N];
    typedef logic signed [CF_W-1:0]  coef_row_t [N];

    function automatic res_row_t unpack_res(input logic [N*RES_W-1:0] v);
        res_row_t r;
        for (int j = 0; j < N; j++) begin
            r[j] = v[j*RES_W +: RES_W];
        end
        return r;
    endfunction

    function automatic logic [N*RES_W-1:0] pack_res(input res_row_t r);
        logic [N*RES_W-1:0] v;
        v = '0;
        for (int j = 0; j < N; j++) begin
            v[j*RES_W +: RES_W] = r[j];
        end
        return v;
    endfunction

    function automatic coef_row_t unpack_coef(input logic [N*CF_W-1:0] v);
        coef_row_t r;
        for (int j = 0; j < N; j++) begin
            r[j] = v[j*CF_W +: CF_W];
        end
        return r;
    endfunction

    function automatic logic [N*CF_W-1:0] pack_coef(input coef_row_t r);
        logic [N*CF_W-1:0] v;
        v = '0;
        for (int j = 0; j < N; j++) begin
            v[j*CF_W +: CF_W] = r[j];
        end
        return v;
    endfunction

endpackage

// File: rtl/dst4x4_top.sv
// Combinational 4x4 DST core: Y = round((M * X * M^T) / 2^SHIFT).
// Element [r][c] of either block sits at flat index (r*4 + c).
module dst4x4_top #(
    parameter int IN_W    = 12,
    parameter int COEFF_W = 8,
    parameter int MID_W   = 20,
    parameter int OUT_W   = 16,
    parameter int SHIFT   = 14
) (
    input  logic [16*IN_W-1:0]  in_block,
    output logic [16*OUT_W-1:0] out_block
);

    localparam int ACC_W = MID_W + COEFF_W + 2;
    localparam int M [4][4] = '{
        '{29,  55,  74,  84},
        '{74,  74,   0, -74},
        '{84, -29, -74,  55},
        '{55, -84,  74, -29}
    };
    localparam logic signed [ACC_W-1:0] RND = ACC_W'(1) <<< (SHIFT - 1);

    function automatic logic signed [COEFF_W-1:0] cf(input int r, input int k);
        return COEFF_W'(M[r][k]);
    endfunction

    logic signed [MID_W-1:0] mid [4][4];
    logic signed [ACC_W-1:0] acc1;
    logic signed [ACC_W-1:0] acc2;
    logic signed [ACC_W-1:0] sh;

    // first pass transforms columns, kept unshifted at full precision
    always_comb begin
        acc1 = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                acc1 = '0;
                for (int k = 0; k < 4; k++) begin
                    acc1 = acc1 + ACC_W'(cf(r, k))
                         * ACC_W'($signed(in_block[(k*4+c)*IN_W +: IN_W]));
                end
                mid[r][c] = acc1[MID_W-1:0];
            end
        end
    end

    always_comb begin
        acc2 = '0;
        sh = '0;
        out_block = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                acc2 = '0;
                for (int k = 0; k < 4; k++) begin
                    acc2 = acc2 + ACC_W'(mid[r][k]) * ACC_W'(cf(c, k));
                end
                sh = (acc2 + RND) >>> SHIFT;
                out_block[(r*4+c)*OUT_W +: OUT_W] = sh[OUT_W-1:0];
            end
        end
    end

endmodule

// File: rtl/dst4x4_ctrl.sv
// Streaming sequencer around dst4x4_top: gathers four residual rows,
// evaluates the core for one cycle, then drains four coefficient rows.
module dst4x4_ctrl
    import dst_pkg::*;
#(
    parameter int IN_W    = RES_W,
    parameter int COEFF_W = 8,
    parameter int MID_W   = 20,
    parameter int OUT_W   = CF_W,
    parameter int SHIFT   = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sof,
    input  logic [4*IN_W-1:0] in_row,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [4*OUT_W-1:0] out_row,
    output logic              out_last,
    output logic              busy,
    output logic              err_sync
);

    state_t     state;
    logic [1:0] row_cnt;
    logic [1:0] out_cnt;
    res_row_t   inbuf [N];
    coef_row_t  outbuf [N];

    logic [16*IN_W-1:0]  core_in;
    logic [16*OUT_W-1:0] core_out;

    always_comb begin
        core_in = '0;
        for (int r = 0; r < N; r++) begin
            core_in[r*N*IN_W +: N*IN_W] = pack_res(inbuf[r]);
        end
    end

    dst4x4_top #(
        .IN_W    (IN_W),
        .COEFF_W (COEFF_W),
        .MID_W   (MID_W),
        .OUT_W   (OUT_W),
        .SHIFT   (SHIFT)
    ) u_core (
        .in_block  (core_in),
        .out_block (core_out)
    );

    assign in_ready = (state == FILL) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FILL;
            row_cnt   <= 2'd0;
            out_cnt   <= 2'd0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            err_sync  <= 1'b0;
            out_row   <= '0;
            for (int r = 0; r < N; r++) begin
                inbuf[r]  <= '{default: '0};
                outbuf[r] <= '{default: '0};
            end
        end else begin
            err_sync <= 1'b0;
            unique case (state)
                FILL: begin
                    if (in_valid) begin
                        if (in_sof) begin
                            // sof always restarts a block, even on row 3
                            inbuf[0] <= unpack_res(in_row);
                            row_cnt  <= 2'd1;
                            err_sync <= (row_cnt != 2'd0);
                        end else if (row_cnt == 2'd0) begin
                            err_sync <= 1'b1;
                        end else begin
                            inbuf[row_cnt] <= unpack_res(in_row);
                            if (row_cnt == 2'd3) begin
                                row_cnt <= 2'd0;
                                state   <= XFORM;
                                busy    <= 1'b1;
                            end else begin
                                row_cnt <= row_cnt + 2'd1;
                            end
                        end
                    end
                end
                XFORM: begin
                    for (int r = 0; r < N; r++) begin
                        outbuf[r] <= unpack_coef(core_out[r*N*OUT_W +: N*OUT_W]);
                    end
                    out_row   <= core_out[N*OUT_W-1:0];
                    out_valid <= 1'b1;
                    out_last  <= 1'b0;
                    out_cnt   <= 2'd0;
                    state     <= DRAIN;
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (out_cnt == 2'd3) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            busy      <= 1'b0;
                            state     <= FILL;
                        end else begin
                            out_cnt  <= out_cnt + 2'd1;
                            out_row  <= pack_coef(outbuf[out_cnt + 2'd1]);
                            out_last <= (out_cnt == 2'd2);
                        end
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_dst4x4_ctrl.sv
// Bench for dst4x4_ctrl: directed and random blocks against a matrix-level
// DST model plus a row-framing model.
module tb_dst4x4_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_sof;
    logic [47:0] in_row;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_row;
    logic        out_last;
    logic        busy;
    logic        err_sync;

    dst4x4_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sof    (in_sof),
        .in_row    (in_row),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_row   (out_row),
        .out_last  (out_last),
        .busy      (busy),
        .err_sync  (err_sync)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int err_cnt = 0;
    int busy_cnt = 0;
    int exp_err = 0;
    int pcnt = 0;
    int pbuf [4][4];
    bit rnd_rdy = 1'b0;

    logic [63:0] got_q [$];
    logic [63:0] exp_q [$];
    logic        got_l [$];
    logic        exp_l [$];
    int          got_c [$];
    int          acc_c [$];

    logic        p_stall = 1'b0;
    logic [63:0] p_row;
    logic        p_last;

    int dstm [4][4] = '{
        '{29,  55,  74,  84},
        '{74,  74,   0, -74},
        '{84, -29, -74,  55},
        '{55, -84,  74, -29}
    };

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst && p_stall) begin
            vectors++;
            assert (out_row === p_row && out_last === p_last) else begin
                miscompares++;
                $error("FAIL hold: got %h/%b want %h/%b", out_row, out_last, p_row, p_last);
            end
        end
        p_stall = !rst && out_valid && !out_ready;
        p_row = out_row;
        p_last = out_last;
        if (!rst && out_valid && out_ready) begin
            got_q.push_back(out_row);
            got_l.push_back(out_last);
            got_c.push_back(cyc);
        end
        if (!rst && in_valid && in_ready) acc_c.push_back(cyc);
        if (err_sync) err_cnt++;
        if (busy) busy_cnt++;
    end

    task automatic chkr(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %b want %b", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
    endtask

    function automatic logic [47:0] pk(input int rr[4]);
        logic [47:0] v;
        int s;
        v = '0;
        for (int j = 0; j < 4; j++) begin
            s = rr[j];
            v[j*12 +: 12] = s[11:0];
        end
        return v;
    endfunction

    task automatic rnd_row(output int rr[4]);
        for (int j = 0; j < 4; j++) rr[j] = int'($urandom_range(0, 4095)) - 2048;
    endtask

    // Y = round(M X M^T / 2^14) in plain integer arithmetic
    task automatic push_block(input int x[4][4]);
        int mid [4][4];
        int acc;
        int y;
        logic [63:0] row;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                mid[r][c] = 0;
                for (int k = 0; k < 4; k++) mid[r][c] += dstm[r][k] * x[k][c];
            end
        for (int r = 0; r < 4; r++) begin
            row = '0;
            for (int c = 0; c < 4; c++) begin
                acc = 0;
                for (int k = 0; k < 4; k++) acc += mid[r][k] * dstm[c][k];
                y = (acc + 8192) >>> 14;
                row[c*16 +: 16] = y[15:0];
            end
            exp_q.push_back(row);
            exp_l.push_back(r == 3);
        end
    endtask

    task automatic model_row(input int rr[4], input bit s);
        if (s) begin
            if (pcnt != 0) exp_err++;
            pbuf[0] = rr;
            pcnt = 1;
        end else if (pcnt == 0) begin
            exp_err++;
        end else begin
            pbuf[pcnt] = rr;
            pcnt++;
            if (pcnt == 4) begin
                push_block(pbuf);
                pcnt = 0;
            end
        end
    endtask

    task automatic put(input int rr[4], input bit s);
        int t;
        logic a;
        model_row(rr, s);
        t = 0;
        a = 1'b0;
        in_valid = 1'b1;
        in_row = pk(rr);
        in_sof = s;
        while (!a && t < 200) begin
            @(negedge clk);
            a = in_ready;
            step();
            t++;
        end
        in_valid = 1'b0;
        chkb("in_accept", a, 1'b1);
    endtask

    task automatic wait_out();
        int t;
        t = 0;
        while (got_q.size() < exp_q.size() && t < 2000) begin
            step();
            t++;
        end
        repeat (4) step();
    endtask

    task automatic check_out(input string tag);
        chki({tag, ":rows"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            chkr({tag, ":row"}, got_q[i], exp_q[i]);
            chkb({tag, ":last"}, got_l[i], exp_l[i]);
        end
        chki({tag, ":err"}, err_cnt, exp_err);
        got_q.delete();
        got_l.delete();
        got_c.delete();
        exp_q.delete();
        exp_l.delete();
    endtask

    initial begin
        int b1 [4][4];
        int zb [4][4];
        int rr [4];
        int t;
        bit s;
        b1 = '{'{10, 20, 30, 40}, '{-5, -15, -25, -35},
               '{12, 0, -12, -24}, '{8, 16, -8, -16}};
        zb = '{default: 0};
        rst = 1'b1;
        in_valid = 1'b0;
        in_sof = 1'b0;
        in_row = '0;
        out_ready = 1'b1;

        step();
        chkb("rst_valid", out_valid, 1'b0);
        chkb("rst_last", out_last, 1'b0);
        chkb("rst_busy", busy, 1'b0);
        chkb("rst_err", err_sync, 1'b0);
        chkr("rst_row", out_row, 64'h0);
        chkb("rst_in_ready", in_ready, 1'b0);
        step();
        rst = 1'b0;
        #1;
        chkb("idle_in_ready", in_ready, 1'b1);

        // reference block followed immediately by an all-zero block
        acc_c.delete();
        for (int r = 0; r < 4; r++) put(b1[r], r == 0);
        put(zb[0], 1'b1);
        busy_cnt = 0;
        for (int r = 1; r < 4; r++) put(zb[r], 1'b0);
        wait_out();
        chki("latency", got_c[0] - acc_c[3], 2);
        chki("period", acc_c[4] - acc_c[0], 9);
        chki("busy_cycles", busy_cnt, 5);
        check_out("blk");

        // backpressure while row 1 is presented
        out_ready = 1'b0;
        for (int r = 0; r < 4; r++) begin
            rnd_row(rr);
            put(rr, r == 0);
        end
        t = 0;
        while (!out_valid && t < 50) begin
            step();
            t++;
        end
        chkb("bp_valid", out_valid, 1'b1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chkb("bp_in_ready", in_ready, 1'b0);
            chkb("bp_out_valid", out_valid, 1'b1);
            chkb("bp_last", out_last, 1'b0);
            step();
        end
        out_ready = 1'b1;
        wait_out();
        check_out("bp");

        // resync: two rows, then a fresh sof and three more rows
        for (int r = 0; r < 6; r++) begin
            rnd_row(rr);
            put(rr, r == 0 || r == 2);
        end
        wait_out();
        check_out("resync");

        // first row without sof is dropped
        rnd_row(rr);
        put(rr, 1'b0);
        for (int r = 0; r < 4; r++) begin
            rnd_row(rr);
            put(rr, r == 0);
        end
        wait_out();
        check_out("nosof");

        // reset during drain after row 1 leaves
        for (int r = 0; r < 4; r++) begin
            rnd_row(rr);
            put(rr, r == 0);
        end
        t = 0;
        while (got_q.size() < 2 && t < 50) begin
            step();
            t++;
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        pcnt = 0;
        while (exp_q.size() > 2) begin
            void'(exp_q.pop_back());
            void'(exp_l.pop_back());
        end
        chkb("rst_drain_valid", out_valid, 1'b0);
        chkb("rst_drain_busy", busy, 1'b0);
        repeat (10) step();
        check_out("rst_drain");
        for (int r = 0; r < 4; r++) begin
            rnd_row(rr);
            put(rr, r == 0);
        end
        wait_out();
        check_out("post_rst");

        // random rows, occasional framing errors, random out_ready
        rnd_rdy = 1'b1;
        for (int i = 0; i < 48; i++) begin
            rnd_row(rr);
            s = ((i % 4) == 0) ^ ($urandom_range(0, 9) == 0);
            put(rr, s);
        end
        wait_out();
        rnd_rdy = 1'b0;
        out_ready = 1'b1;
        check_out("random");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
